idu_ir_freelist: RTL and testbench
==================================

IDU_IR_FREELIST -- requirements
Module: idu_ir_freelist

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-002 The module SHALL have port rst_clk, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have port rtu_global_flush, input, 1 bit: pipeline flush, restore speculative state.
REQ-004 The module SHALL have port y_idu_ir_stall_ctrl, input, 1 bit: IR stage stall, blocks allocation only.
REQ-005 The module SHALL have port alloc_req, input, 1 bit: rename needs a destination preg this cycle.
REQ-006 The module SHALL have port alloc_vld, output, 1 bit: alloc_preg is valid and the allocation fires.
REQ-007 The module SHALL have port alloc_preg, output, 6 bits: preg handed to the rename table as update_preg.
REQ-008 The module SHALL have port rtu_retire_vld, input, 1 bit: a destination-writing instruction retires.
REQ-009 The module SHALL have port rtu_retire_release_preg, input, 6 bits: previous mapping of the retired dst, returned to the free list.
REQ-010 The module SHALL have port free_cnt, output, 6 bits: number of free entries, range 0..32.
REQ-011 The module SHALL have port empty, output, 1 bit: free_cnt == 0.

Function
REQ-012 The design SHALL have 64 pregs; 0..31 are architecturally mapped at reset; the free list is a 32-entry x 6-bit circular buffer.
REQ-013 There SHALL be three 6-bit pointers (5-bit index + wrap bit): spec_head (alloc), cmt_head (committed alloc), tail (release).
REQ-014 free_cnt SHALL be tail - spec_head, modulo 64 (combinational); empty SHALL be (free_cnt == 0).
REQ-015 alloc_preg SHALL be entry[spec_head index] (combinational).
REQ-016 alloc_vld SHALL be alloc_req & !empty & !y_idu_ir_stall_ctrl & !rtu_global_flush.
REQ-017 When alloc_vld is 1, spec_head SHALL increment by 1 at the clock edge; zero latency from request to preg.
REQ-018 When rtu_retire_vld is 1, entry[tail] SHALL be written with rtu_retire_release_preg, and tail and cmt_head SHALL each increment by 1.
REQ-019 Retire SHALL be unaffected by stall and flush; it proceeds in every cycle that rtu_retire_vld is 1.
REQ-020 When rtu_global_flush is 1, spec_head SHALL be loaded with cmt_head, or with cmt_head+1 if retire fires in the same cycle; no allocation occurs that cycle.
REQ-021 Retire into an empty list SHALL NOT bypass: an entry released in cycle N is allocatable from cycle N+1.
REQ-022 Simultaneous alloc and retire SHALL be legal; free_cnt is unchanged (one in, one out).
REQ-023 Pointers SHALL wrap naturally at 64; full is tail - cmt_head == 32, and a retire while full SHALL trigger a simulation assertion (protocol violation); state is otherwise undefined.
REQ-024 spec_head SHALL never pass tail; an allocation while empty is impossible by REQ-016.

Reset
REQ-025 Async reset SHALL set entry[i] = 32+i for i = 0..31, spec_head = 0, cmt_head = 0, and tail = 6'b100000.
REQ-026 After reset, outputs SHALL be free_cnt = 32, empty = 0, alloc_preg = 32, and alloc_vld = alloc_req.
REQ-027 Reset asserted mid-operation SHALL discard all pointer and entry state immediately and restore the REQ-025 values.

Verification
REQ-028 Reset, then alloc_req held high for 32 cycles -> alloc_preg = 32,33,...,63; then empty = 1, free_cnt = 0, and alloc_vld = 0 on cycle 33.
REQ-029 From empty, retire with release preg 5 -> the same cycle gives alloc_vld = 0; the next cycle gives alloc_preg = 5, free_cnt = 1.
REQ-030 Allocate 3 (32,33,34), retire 1 releasing 7, then flush -> spec_head = cmt_head = 1, free_cnt = 32, alloc_preg = 33.
REQ-031 Flush in the same cycle as retire and alloc_req -> alloc_vld = 0, spec_head = old cmt_head + 1, and tail increments.
REQ-032 Stall high with alloc_req for 4 cycles -> alloc_vld = 0 and spec_head is unchanged; a concurrent retire still increments free_cnt.
REQ-033 Random alloc/retire for more than 200 cycles crossing the pointer wrap -> no preg is allocated twice without an intervening release, and free_cnt matches the scoreboard.

Source files
------------

// File: rtl/idu_ir_freelist.sv
// Rename-stage physical register free list: 32-entry circular buffer of pregs with
// speculative (spec_head) and committed (cmt_head) allocation pointers and a release tail.
module idu_ir_freelist (
  input  logic       clk,
  input  logic       rst_clk,
  input  logic       rtu_global_flush,
  input  logic       y_idu_ir_stall_ctrl,
  input  logic       alloc_req,
  output logic       alloc_vld,
  output logic [5:0] alloc_preg,
  input  logic       rtu_retire_vld,
  input  logic [5:0] rtu_retire_release_preg,
  output logic [5:0] free_cnt,
  output logic       empty
);

  localparam int unsigned DEPTH = 32;

  logic [5:0] entry [DEPTH];
  logic [5:0] spec_head;
  logic [5:0] cmt_head;
  logic [5:0] tail;
  logic [5:0] spec_head_nxt;
  logic [5:0] cmt_head_nxt;
  logic [5:0] tail_nxt;
  logic       full;

  always_comb begin
    free_cnt   = tail - spec_head;
    empty      = (free_cnt == '0);
    // tail - cmt_head stays at 32 by construction, so the list holding all 32
    // pregs (nothing left in flight to retire) is seen as spec_head == cmt_head.
    full       = (free_cnt == 6'd32);
    alloc_preg = entry[spec_head[4:0]];
    alloc_vld  = alloc_req & ~empty & ~y_idu_ir_stall_ctrl & ~rtu_global_flush;
  end

  always_comb begin
    cmt_head_nxt  = cmt_head + {5'd0, rtu_retire_vld};
    tail_nxt      = tail + {5'd0, rtu_retire_vld};
    spec_head_nxt = spec_head;
    if (rtu_global_flush) begin
      spec_head_nxt = cmt_head_nxt;
    end else if (alloc_vld) begin
      spec_head_nxt = spec_head + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      spec_head <= '0;
      cmt_head  <= '0;
      tail      <= 6'b100000;
    end else begin
      spec_head <= spec_head_nxt;
      cmt_head  <= cmt_head_nxt;
      tail      <= tail_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry[i] <= 6'(DEPTH + i);
      end
    end else if (rtu_retire_vld) begin
      entry[tail[4:0]] <= rtu_retire_release_preg;
    end
  end

  a_no_retire_when_full: assert property (
    @(posedge clk) disable iff (!rst_clk) !(rtu_retire_vld && full)
  ) else $error("idu_ir_freelist: retire while free list full");

  a_free_cnt_range: assert property (
    @(posedge clk) disable iff (!rst_clk) (free_cnt <= 6'd32)
  ) else $error("idu_ir_freelist: spec_head passed tail");

endmodule

// File: tb/tb_idu_ir_freelist.sv
// Self-checking bench for idu_ir_freelist: queue-based reference model of free,
// in-flight and architecturally mapped pregs, directed scenarios plus random traffic.
module tb_idu_ir_freelist;

  logic       clk;
  logic       rst_clk;
  logic       rtu_global_flush;
  logic       y_idu_ir_stall_ctrl;
  logic       alloc_req;
  logic       alloc_vld;
  logic [5:0] alloc_preg;
  logic       rtu_retire_vld;
  logic [5:0] rtu_retire_release_preg;
  logic [5:0] free_cnt;
  logic       empty;

  idu_ir_freelist dut (
    .clk                     (clk),
    .rst_clk                 (rst_clk),
    .rtu_global_flush        (rtu_global_flush),
    .y_idu_ir_stall_ctrl     (y_idu_ir_stall_ctrl),
    .alloc_req               (alloc_req),
    .alloc_vld               (alloc_vld),
    .alloc_preg              (alloc_preg),
    .rtu_retire_vld          (rtu_retire_vld),
    .rtu_retire_release_preg (rtu_retire_release_preg),
    .free_cnt                (free_cnt),
    .empty                   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // freeq: allocatable pregs in allocation order; infl: allocated, not yet retired;
  // mapped: committed architectural mappings.
  logic [5:0] freeq  [$];
  logic [5:0] infl   [$];
  logic [5:0] mapped [$];
  logic [5:0] mp;
  logic       m_fire;
  logic       m_empty;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    freeq.delete();
    infl.delete();
    mapped.delete();
    for (int i = 0; i < 32; i++) begin
      freeq.push_back(6'(32 + i));
      mapped.push_back(6'(i));
    end
  endfunction

  function automatic void take_mapped(logic [5:0] p);
    for (int i = 0; i < mapped.size(); i++) begin
      if (mapped[i] == p) begin
        mapped.delete(i);
        return;
      end
    end
  endfunction

  function automatic int is_busy(logic [5:0] p);
    for (int i = 0; i < mapped.size(); i++) if (mapped[i] == p) return 1;
    for (int i = 0; i < infl.size(); i++) if (infl[i] == p) return 1;
    return 0;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin
    if (rst_clk) begin
      m_fire = alloc_req && (freeq.size() != 0) && !y_idu_ir_stall_ctrl && !rtu_global_flush;
      if (m_fire) begin
        mp = freeq.pop_front();
        infl.push_back(mp);
      end
      if (rtu_retire_vld) begin
        if (infl.size() != 0) begin
          mp = infl.pop_front();
          mapped.push_back(mp);
        end
        take_mapped(rtu_retire_release_preg);
        freeq.push_back(rtu_retire_release_preg);
      end
      if (rtu_global_flush) begin
        while (infl.size() != 0) freeq.push_front(infl.pop_back());
      end
    end
  end

  // Compare process: outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    if (!rst_clk) model_reset();
    m_empty = (freeq.size() == 0);
    chk("free_cnt", int'(free_cnt), freeq.size());
    chk("empty", int'(empty), int'(m_empty));
    chk("alloc_vld", int'(alloc_vld),
        int'(alloc_req && !m_empty && !y_idu_ir_stall_ctrl && !rtu_global_flush));
    if (!m_empty) chk("alloc_preg", int'(alloc_preg), int'(freeq[0]));
    if (alloc_vld) chk("alloc_unique", is_busy(alloc_preg), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic st, input logic fl,
                       input logic rv, input logic [5:0] rel);
    alloc_req               = req;
    y_idu_ir_stall_ctrl     = st;
    rtu_global_flush        = fl;
    rtu_retire_vld          = rv;
    rtu_retire_release_preg = rel;
  endtask

  int exp_f [4];

  initial begin
    model_reset();
    rst_clk = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);

    // Reset values
    @(negedge clk);
    chk("rst_free_cnt", int'(free_cnt), 32);
    chk("rst_alloc_preg", int'(alloc_preg), 32);
    chk("rst_empty", int'(empty), 0);
    chk("rst_alloc_vld", int'(alloc_vld), 1);
    tick();
    rst_clk = 1'b1;

    // Drain all 32 entries in order
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("drain_vld", int'(alloc_vld), 1);
      chk("drain_preg", int'(alloc_preg), 32 + i);
      tick();
    end
    @(negedge clk);
    chk("drained_empty", int'(empty), 1);
    chk("drained_free_cnt", int'(free_cnt), 0);
    chk("drained_vld", int'(alloc_vld), 0);
    tick();

    // Retire into empty list: no bypass
    drive(1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
    @(negedge clk);
    chk("nobypass_vld", int'(alloc_vld), 0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    chk("released_vld", int'(alloc_vld), 1);
    chk("released_preg", int'(alloc_preg), 5);
    chk("released_free_cnt", int'(free_cnt), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);

    // Asynchronous reset in mid-cycle
    #2 rst_clk = 1'b0;
    @(negedge clk);
    chk("midrst_free_cnt", int'(free_cnt), 32);
    chk("midrst_alloc_preg", int'(alloc_preg), 32);
    tick();
    rst_clk = 1'b1;

    // Allocate 3, retire 1, flush
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a3_preg", int'(alloc_preg), 32 + i);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 6'd7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    chk("flush_vld", int'(alloc_vld), 0);
    chk("preflush_free_cnt", int'(free_cnt), 30);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    chk("postflush_free_cnt", int'(free_cnt), 32);
    chk("postflush_preg", int'(alloc_preg), 33);

    // Flush together with retire and alloc_req
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd8);
    @(negedge clk);
    chk("flushret_vld", int'(alloc_vld), 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    chk("flushret_free_cnt", int'(free_cnt), 32);
    chk("flushret_preg", int'(alloc_preg), 34);

    // Stall blocks alloc but not retire
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    tick();
    exp_f = '{30, 31, 31, 32};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, (k == 0 || k == 2), (k == 0) ? 6'd9 : 6'd10);
      @(negedge clk);
      chk("stall_vld", int'(alloc_vld), 0);
      chk("stall_preg", int'(alloc_preg), 36);
      chk("stall_free_cnt", int'(free_cnt), exp_f[k]);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    chk("poststall_free_cnt", int'(free_cnt), 32);
    tick();

    // Random traffic across several pointer wraps, with one reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 350) begin
        #2 rst_clk = 1'b0;
        tick();
        rst_clk = 1'b1;
      end
      alloc_req           = ($urandom_range(0, 99) < 65);
      y_idu_ir_stall_ctrl = ($urandom_range(0, 99) < 8);
      rtu_global_flush    = ($urandom_range(0, 99) < 4);
      rtu_retire_vld      = (infl.size() != 0) && ($urandom_range(0, 99) < 45);
      if (rtu_retire_vld)
        rtu_retire_release_preg = mapped[$urandom_range(0, mapped.size() - 1)];
      else
        rtu_retire_release_preg = 6'($urandom_range(0, 63));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
